msgmii_txrate_adapt: RTL and testbench
======================================

// Module: msgmii_txrate_adapt
// PURPOSE
//  Parametrised SGMII transmit rate adapter, successor to the fixed 10/100/1000 TX converter.
//  Sits between the MAC GMII transmit interface and the SGMII PCS encoder.
//  Pulls bytes from the MAC over a valid/ready handshake and replicates each byte DIV times (100/10/1).
//  Adds frame-safe speed switching, underrun abort and a resyncable slot-phase counter.
// PARAMETERS
//  DW       8    data width of in_data/out_data
//  DIV_10M  100  slot period in clocks at 10 Mb/s
//  DIV_100M 10   slot period in clocks at 100 Mb/s
//  CNT_W    7    slot divider width; must hold DIV_10M-1
//  PH_W     3    slot-phase counter width
// PORTS
//  clk          in   1     transmit clock (125 MHz); all logic on rising edge
//  rst          in   1     asynchronous, active-high reset
//  speed        in   2     00=10M 01=100M 10=1000M 11=treated as 1000M
//  phase_init   in   PH_W  phase value loaded at frame start
//  in_data      in   DW    MAC transmit byte
//  in_en        in   1     MAC transmit enable for in_data
//  in_er        in   1     MAC transmit error for in_data
//  in_valid     in   1     in_data/in_en/in_er valid
//  in_ready     out  1     slot open; byte accepted when in_valid&in_ready
//  out_data     out  DW    replicated byte to PCS
//  out_en       out  1     replicated transmit enable
//  out_er       out  1     replicated transmit error
//  out_strobe   out  1     1 on first clock of each new slot on the outputs
//  phase        out  PH_W  slot-phase counter
//  speed_active out  2     speed currently in effect
//  underrun     out  1     1-clock pulse on mid-frame starvation
// BEHAVIOUR
//  Reset: all outputs 0 (including in_ready); div_cnt=0; state IDLE; speed_active=10.
//  Reset is async: out_en/out_er drop immediately, even mid-frame. First clock after release opens a slot.
//  Divider: DIV = DIV_10M, DIV_100M or 1 per speed_active. in_ready = (div_cnt==0) & ~rst.
//  Divider counting: at 0, reload DIV-1; otherwise decrement. For DIV=1, div_cnt stays 0.
//  Slot: clock with div_cnt==0. Outputs update only on slot edges and hold DIV clocks.
//  Latency: byte accepted at clock t appears on the outputs at t+1; out_strobe=1 at t+1 only.
//  speed_active loads from speed only on a slot edge while state==IDLE and no frame start is being accepted.
//  Mid-frame speed changes are deferred until the frame ends.
//  Load order at a slot: the new speed_active governs the reload of that same slot.
//  States:
//   IDLE:  accept with in_en=1 -> FRAME, output byte.
//          Otherwise output en=0, er=in_er&in_valid, data=in_data (accepted) or 0.
//   FRAME: accept with in_en=1 -> output byte.
//          Accept with in_en=0 -> IDLE, output en=0.
//          Slot with in_valid=0 -> ABORT, output en=1 er=1 data=0, underrun=1 for one clock.
//   ABORT: output held en=1 er=1 data=0 each slot. Accepted bytes with in_en=1 are discarded.
//          Accept with in_en=0 -> IDLE, output en=0.
//  in_ready does not depend on state; the MAC is always drained at slot rate.
//  Phase counter:
//   - IDLE accept with in_en=1 (frame start): phase <= phase_init.
//   - Any other slot: phase <= phase+1, wrapping at 2^PH_W.
//  Arithmetic: all counters are unsigned, modulo their width. No saturation.
//  Simultaneous events:
//   - speed change on a frame-start slot: ignored, speed_active unchanged.
//   - underrun and reset: reset wins.
// TESTING
//  1 speed=10, frame 55 55 D5 AA 01 then in_en=0 -> in_ready always 1; out = in delayed 1 clk; out_strobe=1 every clk.
//  2 speed=01, accept 0x5A en=1 -> out_data=0x5A, out_en=1 for exactly 10 clks; in_ready=1 once per 10 clks.
//  3 speed=00, phase_init=3, frame of 6 bytes -> each byte held 100 clks; phase 3,4,5,6,7,0; wrap checked.
//  4 speed 01->00 mid-frame -> speed_active stays 01 until the in_en=0 slot; next slot reloads 99.
//  5 speed=01, in_valid=0 at the 3rd frame slot -> out en=1 er=1 data=00; underrun 1-clk pulse.
//    Then the ABORT hold persists; in_en=0 accept -> out_en=0.
//  6 rst asserted mid-frame at 10M -> all outputs 0 asynchronously; in_ready=1 the clock after release.

Source files
------------

// File: rtl/msgmii_txrate_adapt.sv
`default_nettype none
// ============================================================================
//  Module      : msgmii_txrate_adapt
//  Description : SGMII transmit rate adapter. Pulls GMII bytes from the MAC
//                at one byte per slot and holds each for DIV clocks
//                (100/10/1). Handles frame-safe speed switching, underrun
//                abort and a loadable slot-phase counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module msgmii_txrate_adapt #(
  parameter int DW       = 8,
  parameter int DIV_10M  = 100,
  parameter int DIV_100M = 10,
  parameter int CNT_W    = 7,
  parameter int PH_W     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      speed,
  input  logic [PH_W-1:0] phase_init,
  input  logic [DW-1:0]   in_data,
  input  logic            in_en,
  input  logic            in_er,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_en,
  output logic            out_er,
  output logic            out_strobe,
  output logic [PH_W-1:0] phase,
  output logic [1:0]      speed_active,
  output logic            underrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  localparam logic [1:0] c_spd_10m   = 2'b00;
  localparam logic [1:0] c_spd_100m  = 2'b01;
  localparam logic [1:0] c_spd_reset = 2'b10;

  localparam logic [CNT_W-1:0] c_reload_10m  = CNT_W'(DIV_10M - 1);
  localparam logic [CNT_W-1:0] c_reload_100m = CNT_W'(DIV_100M - 1);

  logic [CNT_W-1:0] r_div_cnt;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       r_speed_active;
  logic [1:0]       w_speed_nxt;
  logic [CNT_W-1:0] w_reload;
  logic             w_slot;
  logic             w_start;
  logic             w_speed_load;

  logic [DW-1:0]    r_out_data;
  logic             r_out_en;
  logic             r_out_er;
  logic             r_out_strobe;
  logic             r_underrun;
  logic [PH_W-1:0]  r_phase;

  logic [DW-1:0]    w_data_nxt;
  logic             w_en_nxt;
  logic             w_er_nxt;
  logic             w_under_nxt;
  logic [PH_W-1:0]  w_phase_nxt;

  // A slot opens whenever the divider is at zero; the MAC is drained at slot
  // rate regardless of state, so every slot with in_valid is an acceptance.
  assign w_slot   = (r_div_cnt == '0);
  assign in_ready = w_slot & ~rst;

  // Frame start blocks a speed reload on the same slot.
  assign w_start      = w_slot & in_valid & in_en & (r_state == S_IDLE);
  assign w_speed_load = w_slot & (r_state == S_IDLE) & ~w_start;
  assign w_speed_nxt  = w_speed_load ? speed : r_speed_active;

  // Reload value follows the speed that will be in effect after this slot.
  always_comb begin
    w_reload = '0;
    case (w_speed_nxt)
      c_spd_10m:  w_reload = c_reload_10m;
      c_spd_100m: w_reload = c_reload_100m;
      default:    w_reload = '0;
    endcase
  end

  // Slot divider: reload at each slot, count down between slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_slot) begin
      r_div_cnt <= w_reload;
    end else begin
      r_div_cnt <= r_div_cnt - CNT_W'(1);
    end
  end

  // Active speed register; only changes between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed_active <= c_spd_reset;
    end else begin
      r_speed_active <= w_speed_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, evaluated only on slot edges.
  always_comb begin
    w_state_nxt = r_state;
    if (w_slot) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_en) w_state_nxt = S_FRAME;
        end
        S_FRAME: begin
          if (!in_valid)   w_state_nxt = S_ABORT;
          else if (!in_en) w_state_nxt = S_IDLE;
        end
        S_ABORT: begin
          if (in_valid && !in_en) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: next values for the output registers; hold between slots.
  always_comb begin
    w_data_nxt  = r_out_data;
    w_en_nxt    = r_out_en;
    w_er_nxt    = r_out_er;
    w_under_nxt = 1'b0;
    w_phase_nxt = r_phase;
    if (w_slot) begin
      w_phase_nxt = w_start ? phase_init : r_phase + PH_W'(1);
      case (r_state)
        S_FRAME: begin
          if (!in_valid) begin
            // Starved mid-frame: poison the frame with an error symbol.
            w_data_nxt  = '0;
            w_en_nxt    = 1'b1;
            w_er_nxt    = 1'b1;
            w_under_nxt = 1'b1;
          end else begin
            w_data_nxt = in_data;
            w_en_nxt   = in_en;
            w_er_nxt   = in_er;
          end
        end
        S_ABORT: begin
          if (in_valid && !in_en) begin
            w_data_nxt = in_data;
            w_en_nxt   = 1'b0;
            w_er_nxt   = in_er;
          end else begin
            // Remaining bytes of the aborted frame are discarded.
            w_data_nxt = '0;
            w_en_nxt   = 1'b1;
            w_er_nxt   = 1'b1;
          end
        end
        default: begin
          if (in_valid) begin
            w_data_nxt = in_data;
            w_en_nxt   = in_en;
            w_er_nxt   = in_er;
          end else begin
            w_data_nxt = '0;
            w_en_nxt   = 1'b0;
            w_er_nxt   = 1'b0;
          end
        end
      endcase
    end
  end

  // Output registers: one clock of latency from acceptance to PCS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_en     <= 1'b0;
      r_out_er     <= 1'b0;
      r_out_strobe <= 1'b0;
      r_underrun   <= 1'b0;
      r_phase      <= '0;
    end else begin
      r_out_data   <= w_data_nxt;
      r_out_en     <= w_en_nxt;
      r_out_er     <= w_er_nxt;
      r_out_strobe <= w_slot;
      r_underrun   <= w_under_nxt;
      r_phase      <= w_phase_nxt;
    end
  end

  assign out_data     = r_out_data;
  assign out_en       = r_out_en;
  assign out_er       = r_out_er;
  assign out_strobe   = r_out_strobe;
  assign underrun     = r_underrun;
  assign phase        = r_phase;
  assign speed_active = r_speed_active;

endmodule
`default_nettype wire

// File: tb/tb_msgmii_txrate_adapt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msgmii_txrate_adapt
//  Description : Scoreboard bench for msgmii_txrate_adapt. A frame-level
//                reference model predicts every slot's output; a monitor
//                compares on out_strobe and checks holds between slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msgmii_txrate_adapt;

  localparam int DW   = 8;
  localparam int PH_W = 3;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_FRAME = 1;
  localparam int MODE_ABORT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      speed = 2'b10;
  logic [PH_W-1:0] phase_init = '0;
  logic [DW-1:0]   in_data = '0;
  logic            in_en = 1'b0;
  logic            in_er = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic            out_en;
  logic            out_er;
  logic            out_strobe;
  logic [PH_W-1:0] phase;
  logic [1:0]      speed_active;
  logic            underrun;

  msgmii_txrate_adapt dut (
    .clk          (clk),
    .rst          (rst),
    .speed        (speed),
    .phase_init   (phase_init),
    .in_data      (in_data),
    .in_en        (in_en),
    .in_er        (in_er),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_en       (out_en),
    .out_er       (out_er),
    .out_strobe   (out_strobe),
    .phase        (phase),
    .speed_active (speed_active),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       en;
    logic       er;
    logic       un;
    logic [2:0] ph;
    logic [1:0] spd;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  // Reference model state (frame-level view)
  int         m_mode;
  int         m_left;   // clocks remaining until the next slot
  logic [1:0] m_speed;
  int         m_phase;

  function automatic int slot_len(input logic [1:0] s);
    if (s == 2'b00) return 100;
    if (s == 2'b01) return 10;
    return 1;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_mode   = MODE_IDLE;
    m_left   = 0;
    m_speed  = 2'b10;
    m_phase  = 0;
    last_exp = '{d: 8'h00, en: 1'b0, er: 1'b0, un: 1'b0, ph: 3'd0, spd: 2'b10};
  endtask

  task automatic model_slot(input logic v, input logic en, input logic er,
                            input logic [7:0] d, input logic [1:0] spd,
                            input logic [2:0] pi);
    exp_t e;
    bit   start;
    start = (m_mode == MODE_IDLE) && v && en;
    if (m_mode == MODE_IDLE && !start) m_speed = spd;
    m_left = slot_len(m_speed) - 1;
    e = '0;
    case (m_mode)
      MODE_IDLE: begin
        if (start) begin
          e.d = d; e.en = 1'b1; e.er = er; m_mode = MODE_FRAME;
        end else begin
          e.d = v ? d : 8'h00; e.en = 1'b0; e.er = v ? er : 1'b0;
        end
      end
      MODE_FRAME: begin
        if (!v) begin
          e.d = 8'h00; e.en = 1'b1; e.er = 1'b1; e.un = 1'b1; m_mode = MODE_ABORT;
        end else if (en) begin
          e.d = d; e.en = 1'b1; e.er = er;
        end else begin
          e.d = d; e.en = 1'b0; e.er = er; m_mode = MODE_IDLE;
        end
      end
      default: begin
        if (v && !en) begin
          e.d = d; e.en = 1'b0; e.er = er; m_mode = MODE_IDLE;
        end else begin
          e.d = 8'h00; e.en = 1'b1; e.er = 1'b1;
        end
      end
    endcase
    m_phase = start ? int'(pi) : (m_phase + 1) % 8;
    e.ph  = m_phase[2:0];
    e.spd = m_speed;
    sb.push_back(e);
  endtask

  // Body of one clock step at the falling edge: verify the previous slot was
  // observed, check in_ready, drive inputs, and advance the model.
  task automatic step_body(input logic v, input logic en, input logic er,
                           input logic [7:0] d, input logic [1:0] spd,
                           input logic [2:0] pi);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_strobe t=%0t pending=%0d exp=%h", $time, sb.size(), sb[0]);
      sb.delete();
    end
    checks++;
    if (in_ready !== (m_left == 0)) begin
      errors++;
      $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, (m_left == 0));
    end
    in_valid   = v;
    in_en      = en;
    in_er      = er;
    in_data    = d;
    speed      = spd;
    phase_init = pi;
    if (m_left == 0) model_slot(v, en, er, d, spd, pi);
    else m_left--;
  endtask

  task automatic step(input logic v, input logic en, input logic er,
                      input logic [7:0] d, input logic [1:0] spd,
                      input logic [2:0] pi);
    @(negedge clk);
    step_body(v, en, er, d, spd, pi);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset(input logic [1:0] spd);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_en !== 1'b0 || out_er !== 1'b0 || out_data !== 8'h00 ||
        out_strobe !== 1'b0 || underrun !== 1'b0 || phase !== 3'd0 ||
        speed_active !== 2'b10 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state t=%0t got en=%b er=%b d=%h stb=%b un=%b ph=%0d spd=%b rdy=%b exp all 0, spd=10",
               $time, out_en, out_er, out_data, out_strobe, underrun, phase, speed_active, in_ready);
    end
    model_reset();
    in_valid = 1'b0;
    in_en    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    step_body(1'b0, 1'b0, 1'b0, 8'h00, spd, 3'd0);
  endtask

  // Monitor: pop on each strobe, otherwise outputs must hold.
  always @(posedge clk) begin
    exp_t got;
    #1;
    if (!rst) begin
      got = '{d: out_data, en: out_en, er: out_er, un: underrun, ph: phase, spd: speed_active};
      checks++;
      if (out_strobe === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe t=%0t got=%h", $time, got);
        end else begin
          last_exp = sb.pop_front();
          if (got !== last_exp) begin
            errors++;
            $display("FAIL slot_out t=%0t got d=%h en=%b er=%b un=%b ph=%0d spd=%b exp d=%h en=%b er=%b un=%b ph=%0d spd=%b",
                     $time, got.d, got.en, got.er, got.un, got.ph, got.spd,
                     last_exp.d, last_exp.en, last_exp.er, last_exp.un, last_exp.ph, last_exp.spd);
          end
        end
      end else begin
        if (got !== {last_exp[$bits(exp_t)-1:$bits(exp_t)-10], 1'b0, last_exp[4:0]}) begin
          errors++;
          $display("FAIL hold t=%0t got=%h exp=%h (underrun must be 0)", $time, got,
                   {last_exp[$bits(exp_t)-1:$bits(exp_t)-10], 1'b0, last_exp[4:0]});
        end
      end
    end
  end

  initial begin
    logic [7:0] frame1 [5];
    logic [1:0] blk_spd;
    frame1 = '{8'h55, 8'h55, 8'hD5, 8'hAA, 8'h01};
    model_reset();
    do_reset(2'b10);

    // Gigabit: bytes pass through with one clock latency
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, frame1[i], 2'b10, 3'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'b10, 3'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 3'd0);

    // 100M: one byte held for ten clocks
    step(1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 3'd0);
    step(1'b1, 1'b1, 1'b0, 8'h5A, 2'b01, 3'd0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 3'd0);

    // 10M: six-byte frame with phase starting at 3 and wrapping
    step(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 3'd0);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 3'd3);
    for (int i = 0; i < 600; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom), 2'b00, 3'd3);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 3'd3);

    // Mid-frame speed change 100M -> 10M is deferred
    do_reset(2'b01);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom), 2'b01, 3'd1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom), 2'b00, 3'd1);
    for (int i = 0; i < 250; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 3'd1);

    // Underrun at 100M, abort hold, then frame end
    do_reset(2'b01);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom), 2'b01, 3'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 2'b01, 3'd0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom), 2'b01, 3'd0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 3'd0);

    // Reset in the middle of a 10M frame
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 3'd0);
    for (int i = 0; i < 150; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom), 2'b00, 3'd0);
    do_reset(2'b10);

    // Randomized blocks
    for (int b = 0; b < 8; b++) begin
      blk_spd = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 199) == 0) blk_spd = 2'($urandom_range(0, 2));
        step(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 15) == 0), 8'($urandom), blk_spd, 3'($urandom));
      end
      if (b % 3 == 2) do_reset(blk_spd);
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
